// File: rtl/mux_sel_skid.sv
// Purpose : N-way select mux feeding a registered 2-entry skid buffer (main + skid) with valid/ready.
// Latency : 1 cycle from accept to out_* when main is empty or being delivered.
// Backpr. : in_ready = rst_n & ~skid_valid (registered, no comb path from out_ready); out_* hold while stalled.
//
// Ports:
//   clk, rst_n      rising-edge clock, synchronous active-low reset
//   flush           drop every buffered beat (and any beat accepted in the same cycle)
//   in_data         NUM_IN packed operands, operand k = in_data[k*WIDTH +: WIDTH]
//   sel, in_valid   operand index and beat-present qualifier; in_ready back to upstream
//   out_data/sel/err selected operand, raw sel echo, sel-out-of-range flag
//   out_valid       out_* hold a beat; out_ready from downstream
module mux_sel_skid #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // Refuse to elaborate with a select too narrow to address every operand.
    if (NUM_IN < 2 || NUM_IN > 16 || SEL_W < $clog2(NUM_IN)) begin : g_bad_param
        $error("mux_sel_skid: illegal NUM_IN/SEL_W combination");
    end

    // One extra bit so the range compare works even when NUM_IN == 2**SEL_W.
    localparam logic [SEL_W:0] LP_NUM_IN = (SEL_W+1)'(NUM_IN);

    logic [WIDTH-1:0] r_main_dat;
    logic [SEL_W-1:0] r_main_sel;
    logic             r_main_err;
    logic             r_main_vld;

    logic [WIDTH-1:0] r_skid_dat;
    logic [SEL_W-1:0] r_skid_sel;
    logic             r_skid_err;
    logic             r_skid_vld;

    logic             w_sel_ok;
    logic [WIDTH-1:0] w_mux_dat;
    logic             w_accept;
    logic             w_deliver;
    logic             w_main_free;

    assign w_sel_ok = ({1'b0, sel} < LP_NUM_IN);

    // Out-of-range selects produce zero data; the err flag travels with the beat.
    always_comb begin
        w_mux_dat = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_mux_dat = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready    = rst_n & ~r_skid_vld;
    assign w_accept    = in_valid & in_ready;
    assign w_deliver   = r_main_vld & out_ready;
    assign w_main_free = ~r_main_vld | w_deliver;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_main_dat <= '0;
            r_main_sel <= '0;
            r_main_err <= 1'b0;
            r_main_vld <= 1'b0;
            r_skid_dat <= '0;
            r_skid_sel <= '0;
            r_skid_err <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (flush) begin
            // Payload registers keep their last values; only occupancy is dropped.
            r_main_vld <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (w_main_free) begin
            if (r_skid_vld) begin
                // in_ready is low here, so no new beat can compete with the skid entry.
                r_main_dat <= r_skid_dat;
                r_main_sel <= r_skid_sel;
                r_main_err <= r_skid_err;
                r_main_vld <= 1'b1;
                r_skid_vld <= 1'b0;
            end else if (w_accept) begin
                r_main_dat <= w_mux_dat;
                r_main_sel <= sel;
                r_main_err <= ~w_sel_ok;
                r_main_vld <= 1'b1;
            end else begin
                r_main_vld <= 1'b0;
            end
        end else if (w_accept) begin
            // Main is stalled; park the beat. Only reachable while skid is empty.
            r_skid_dat <= w_mux_dat;
            r_skid_sel <= sel;
            r_skid_err <= ~w_sel_ok;
            r_skid_vld <= 1'b1;
        end
    end

    assign out_data  = r_main_dat;
    assign out_sel   = r_main_sel;
    assign out_err   = r_main_err;
    assign out_valid = r_main_vld;

endmodule

// File: tb/tb_mux_sel_skid.sv
module tb_mux_sel_skid;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [127:0] in_data;
    logic [1:0]   sel;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_err;
    logic         out_valid;
    logic         out_ready;

    logic [95:0]  t3_in_data;
    logic [1:0]   t3_sel;
    logic         t3_in_valid;
    logic         t3_in_ready;
    logic [31:0]  t3_out_data;
    logic [1:0]   t3_out_sel;
    logic         t3_out_err;
    logic         t3_out_valid;
    logic         t3_out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_sel_skid #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(in_data), .sel(sel), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_sel_skid #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_data(t3_in_data), .sel(t3_sel), .in_valid(t3_in_valid), .in_ready(t3_in_ready),
        .out_data(t3_out_data), .out_sel(t3_out_sel), .out_err(t3_out_err),
        .out_valid(t3_out_valid), .out_ready(t3_out_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] ops [4];
    logic [33:0] q[$];
    logic [33:0] front;
    logic [31:0] exp_dat;
    bit          acc, dlv;
    int          beats, cycles;

    initial begin
        ops[0] = 32'h11111111; ops[1] = 32'h22222222;
        ops[2] = 32'h33333333; ops[3] = 32'h44444444;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sel = 2'd0;
        in_data = {ops[3], ops[2], ops[1], ops[0]};
        t3_in_data = {ops[2], ops[1], ops[0]};
        t3_sel = 2'd0; t3_in_valid = 1'b0; t3_out_ready = 1'b0;

        // ---- reset / idle ----
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data",  out_data,       32'd0);
            chk("rst_in_ready",  32'(in_ready),  32'd0);
        end
        rst_n = 1'b1;
        step();
        chk("rel_in_ready",   32'(in_ready),    32'd1);
        chk("rel_in_ready3",  32'(t3_in_ready), 32'd1);
        chk("rel_out_valid",  32'(out_valid),   32'd0);

        // ---- streaming select, one beat per cycle ----
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            step();
            chk("str_valid", 32'(out_valid), 32'd1);
            chk("str_data",  out_data,       ops[k]);
            chk("str_sel",   32'(out_sel),   32'(k));
            chk("str_err",   32'(out_err),   32'd0);
        end
        in_valid = 1'b0;
        step();
        chk("str_idle_valid", 32'(out_valid), 32'd0);

        // ---- out-of-range select on the 3-input instance ----
        t3_out_ready = 1'b1;
        t3_in_valid  = 1'b1;
        t3_sel       = 2'd3;
        step();
        chk("oor_valid", 32'(t3_out_valid), 32'd1);
        chk("oor_data",  t3_out_data,       32'd0);
        chk("oor_err",   32'(t3_out_err),   32'd1);
        chk("oor_sel",   32'(t3_out_sel),   32'd3);
        t3_sel = 2'd2;
        step();
        chk("inr_data", t3_out_data,     32'h33333333);
        chk("inr_err",  32'(t3_out_err), 32'd0);
        t3_in_valid = 1'b0;
        step();
        chk("oor_idle", 32'(t3_out_valid), 32'd0);

        // ---- back-pressure: A=op0, B=op1, C=op2 ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel = 2'd0;
        step();
        chk("bp_a_data",  out_data,       32'h11111111);
        chk("bp_a_rdy",   32'(in_ready),  32'd1);
        sel = 2'd1;
        step();
        chk("bp_b_hold",  out_data,       32'h11111111);
        chk("bp_b_rdy",   32'(in_ready),  32'd0);
        sel = 2'd2;
        step();
        chk("bp_c_hold",  out_data,       32'h11111111);
        chk("bp_c_sel",   32'(out_sel),   32'd0);
        chk("bp_c_rdy",   32'(in_ready),  32'd0);
        step();
        chk("bp_c_hold2", out_data,       32'h11111111);
        chk("bp_c_vld2",  32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_out_b",   out_data,       32'h22222222);
        chk("bp_b_rdy1",  32'(in_ready),  32'd1);
        step();
        chk("bp_out_c",   out_data,       32'h33333333);
        chk("bp_out_cv",  32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        chk("bp_drained", 32'(out_valid), 32'd0);

        // ---- flush with main and skid full, D=op1 offered ----
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sel = 2'd3;
        step();
        sel = 2'd0;
        step();
        chk("fl_full_rdy", 32'(in_ready), 32'd0);
        flush = 1'b1;
        sel   = 2'd1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid",    32'(out_valid), 32'd0);
        chk("fl_rdy",      32'(in_ready),  32'd1);
        chk("fl_keepdata", out_data,       32'h44444444);
        out_ready = 1'b1;
        step();
        chk("fl_no_d",     32'(out_valid), 32'd0);
        // flush while a beat is actually accepted: it must be dropped
        in_valid = 1'b1;
        sel = 2'd2;
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_drop_acc", 32'(out_valid), 32'd0);

        // ---- reset mid-operation ----
        out_ready = 1'b0;
        in_valid = 1'b1;
        sel = 2'd3;
        step();
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_data",  out_data,       32'd0);
        chk("mrst_rdy",   32'(in_ready),  32'd0);
        rst_n = 1'b1;
        step();
        chk("mrst_rel",   32'(in_ready),  32'd1);

        // ---- randomised soak against a reference queue ----
        beats = 0;
        cycles = 0;
        while ((beats < 10000 || q.size() != 0) && cycles < 60000) begin
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            sel       = 2'($urandom_range(0, 3));
            in_valid  = (beats < 10000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            out_ready = ($urandom_range(0, 2) != 0);
            chk("soak_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("soak_rdy",   32'(in_ready),  32'(q.size() < 2));
            if (q.size() != 0) begin
                front = q[0];
                chk("soak_data", out_data,     front[31:0]);
                chk("soak_sel",  32'(out_sel), 32'(front[33:32]));
            end
            acc = in_valid && (q.size() < 2);
            dlv = (q.size() != 0) && out_ready;
            if (dlv) void'(q.pop_front());
            if (acc) begin
                exp_dat = in_data[int'(sel)*32 +: 32];
                q.push_back({sel, exp_dat});
                beats++;
            end
            step();
            cycles++;
        end
        chk("soak_done_beats", 32'(beats),    32'd10000);
        chk("soak_done_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
